// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - sliding-window tap scheduler for a stride-1 convolution pass
module conv_window_sched #(
  parameter int IFMAP_W  = 5,
  parameter int FILTER_W = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       READY,
  output logic       ADDR_EN,
  output logic [2:0] IMAGE_idx_msel,
  output logic       ADDR_CLR,
  output logic       TAP_VALID,
  output logic       TAP_FIRST,
  output logic       TAP_LAST,
  output logic [3:0] OFMAP_IDX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int OUT_W = IFMAP_W - FILTER_W + 1;
  localparam int TW    = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
  localparam int OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(FILTER_W - 1);
  localparam logic [OW-1:0] O_MAX = OW'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] tcol, trow;
  logic [OW-1:0] ocol, orow;
  logic          fin_q;
  logic          last_tap;

  // Every counter at its maximum marks the final tap of the whole pass.
  assign last_tap = (tcol == T_MAX) && (trow == T_MAX) &&
                    (ocol == O_MAX) && (orow == O_MAX);

  // State register; fin_q mirrors "state is FIN" so DONE/ADDR_CLR come straight from a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      fin_q <= 1'b0;
    end else begin
      state <= state_nxt;
      fin_q <= (state_nxt == FIN);
    end
  end

  // Window counters: zeroed on the way into RUN, stepped innermost-first on each accepted tap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcol <= '0;
      trow <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (state == IDLE && START) begin
      tcol <= '0;
      trow <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (state == RUN && READY) begin
      if (tcol != T_MAX) begin
        tcol <= tcol + 1'b1;
      end else begin
        tcol <= '0;
        if (trow != T_MAX) begin
          trow <= trow + 1'b1;
        end else begin
          trow <= '0;
          if (ocol != O_MAX) begin
            ocol <= ocol + 1'b1;
          end else begin
            ocol <= '0;
            orow <= (orow == O_MAX) ? '0 : orow + 1'b1;
          end
        end
      end
    end
  end

  // Next-state and tap/address-control decode; the counter is never stepped past the last tap.
  always_comb begin
    state_nxt      = state;
    TAP_VALID      = 1'b0;
    ADDR_EN        = 1'b0;
    IMAGE_idx_msel = 3'd0;
    TAP_FIRST      = 1'b0;
    TAP_LAST       = 1'b0;
    BUSY           = 1'b0;
    DONE           = fin_q;
    ADDR_CLR       = fin_q;
    OFMAP_IDX      = 4'(int'(orow) * OUT_W + int'(ocol));
    case (state)
      IDLE: begin
        if (START) state_nxt = RUN;
      end
      RUN: begin
        BUSY      = 1'b1;
        TAP_VALID = READY;
        ADDR_EN   = READY && !last_tap;
        if (READY && last_tap) state_nxt = FLUSH;
      end
      FLUSH: begin
        BUSY      = 1'b1;
        state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    TAP_FIRST = TAP_VALID && (tcol == '0) && (trow == '0);
    TAP_LAST  = TAP_VALID && (tcol == T_MAX) && (trow == T_MAX);
    if (ADDR_EN) begin
      if (tcol != T_MAX)      IMAGE_idx_msel = 3'd0;
      else if (trow != T_MAX) IMAGE_idx_msel = 3'd1;
      else if (ocol != O_MAX) IMAGE_idx_msel = 3'd2;
      else                    IMAGE_idx_msel = 3'd3;
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// tb/tb_conv_window_sched.sv - scoreboard bench for conv_window_sched with an address-counter model
module tb_conv_window_sched;

  localparam int IW = 5;
  localparam int FW = 3;
  localparam int OW = IW - FW + 1;
  localparam int NT = OW * OW * FW * FW;

  typedef struct {
    int idx;
    int addr;
    bit first;
    bit last;
    int ofm;
    bit en;
    int msel;
  } tap_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic       READY = 1'b0;
  logic       ADDR_EN;
  logic [2:0] IMAGE_idx_msel;
  logic       ADDR_CLR;
  logic       TAP_VALID;
  logic       TAP_FIRST;
  logic       TAP_LAST;
  logic [3:0] OFMAP_IDX;
  logic       BUSY;
  logic       DONE;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cyc_start = 0;
  int   done_cyc = -1;
  int   taps = 0;
  int   lasts = 0;
  int   dones = 0;
  int   addr_m = 0;
  bit   flush_chk = 1'b0;
  tap_t sb[$];

  int delta [4] = '{1, IW - FW + 1, -((FW - 1) * IW + FW - 2), -((FW - 2) * IW + IW - 1)};

  conv_window_sched dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .READY(READY),
    .ADDR_EN(ADDR_EN),
    .IMAGE_idx_msel(IMAGE_idx_msel),
    .ADDR_CLR(ADDR_CLR),
    .TAP_VALID(TAP_VALID),
    .TAP_FIRST(TAP_FIRST),
    .TAP_LAST(TAP_LAST),
    .OFMAP_IDX(OFMAP_IDX),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Image RAM address counter driven by the scheduler's EN/msel/CLR outputs.
  always @(posedge CLK or posedge RST) begin
    if (RST) addr_m <= 0;
    else if (ADDR_CLR) addr_m <= 0;
    else if (ADDR_EN) addr_m <= addr_m + delta[IMAGE_idx_msel[1:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted tap and checks idle-time invariants.
  always begin
    tap_t e;
    @(negedge CLK);
    if (!RST) begin
      if (flush_chk) begin
        chk("addr_held_after_final", addr_m, 24);
        flush_chk = 1'b0;
      end
      if (TAP_VALID) begin
        chk("tap_expected", sb.size() > 0, 1);
        chk("busy_with_tap", BUSY, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("tap%0d_addr", e.idx), addr_m, e.addr);
          chk($sformatf("tap%0d_first", e.idx), TAP_FIRST, e.first);
          chk($sformatf("tap%0d_last", e.idx), TAP_LAST, e.last);
          chk($sformatf("tap%0d_ofmap", e.idx), OFMAP_IDX, e.ofm);
          chk($sformatf("tap%0d_addr_en", e.idx), ADDR_EN, e.en);
          chk($sformatf("tap%0d_msel", e.idx), IMAGE_idx_msel, e.msel);
          if (!e.en) flush_chk = 1'b1;
        end
        taps++;
        if (TAP_LAST) lasts++;
      end else begin
        chk("no_addr_en_without_tap", ADDR_EN, 0);
      end
      if (!READY) chk("no_tap_when_stalled", TAP_VALID, 0);
      if (!ADDR_EN) chk("msel_zero_when_idle", IMAGE_idx_msel, 0);
      chk("clr_with_done", ADDR_CLR, DONE);
      if (DONE) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_pass();
    tap_t e;
    for (int k = 0; k < NT; k++) begin
      int r, w, tc, tr, oc, orw;
      r   = k % (FW * FW);
      w   = k / (FW * FW);
      tc  = r % FW;
      tr  = r / FW;
      oc  = w % OW;
      orw = w / OW;
      e.idx   = k;
      e.addr  = (orw + tr) * IW + oc + tc;
      e.first = (r == 0);
      e.last  = (r == FW * FW - 1);
      e.ofm   = w;
      e.en    = (k != NT - 1);
      e.msel  = !e.en ? 0 : (tc < FW - 1) ? 0 : (tr < FW - 1) ? 1 : (oc < OW - 1) ? 2 : 3;
      sb.push_back(e);
    end
    taps = 0;
    lasts = 0;
    dones = 0;
    done_cyc = -1;
    START = 1'b1;
    cyc_start = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (!DONE && n < budget) begin
      if (rnd) READY = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    READY = 1'b1;
    chk("done_seen", DONE, 1);
    @(negedge CLK);
    #1;
  endtask

  task automatic pass_checks(input bit lat);
    if (lat) chk("done_latency", done_cyc - cyc_start, 83);
    chk("tap_count", taps, NT);
    chk("last_count", lasts, OW * OW);
    chk("scoreboard_drained", sb.size(), 0);
    chk("done_pulses", dones, 1);
  endtask

  task automatic outputs_zero(input string pfx);
    chk({pfx, "_addr_en"}, ADDR_EN, 0);
    chk({pfx, "_msel"}, IMAGE_idx_msel, 0);
    chk({pfx, "_addr_clr"}, ADDR_CLR, 0);
    chk({pfx, "_tap_valid"}, TAP_VALID, 0);
    chk({pfx, "_tap_first"}, TAP_FIRST, 0);
    chk({pfx, "_tap_last"}, TAP_LAST, 0);
    chk({pfx, "_ofmap"}, OFMAP_IDX, 0);
    chk({pfx, "_busy"}, BUSY, 0);
    chk({pfx, "_done"}, DONE, 0);
  endtask

  initial begin
    int n;
    // Reset holds everything at zero even before the first clock edge.
    RST = 1'b1;
    #1;
    outputs_zero("reset_noclk");
    START = 1'b1;
    READY = 1'b1;
    tick();
    tick();
    outputs_zero("reset_clocked");
    START = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_after_reset", BUSY, 0);
    end

    // Single pass with READY held high.
    start_pass();
    wait_done(200, 1'b0);
    pass_checks(1'b1);
    tick();
    chk("addr_cleared_p1", addr_m, 0);

    // Random READY stalls: same tap sequence, exactly one DONE.
    start_pass();
    wait_done(1000, 1'b1);
    pass_checks(1'b0);
    tick();
    chk("addr_cleared_p2", addr_m, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("single_done_p2", dones, 1);

    // START pulses inside RUN and in the FIN cycle are ignored.
    start_pass();
    for (int i = 0; i < 10; i++) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(200, 1'b0);
    pass_checks(1'b1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("addr_cleared_p3", addr_m, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fin_start_not_queued", BUSY, 0);
    end

    // Back-to-back: START in the cycle right after DONE.
    start_pass();
    wait_done(200, 1'b0);
    pass_checks(1'b1);
    tick();
    chk("addr_cleared_p4", addr_m, 0);
    start_pass();
    wait_done(200, 1'b0);
    pass_checks(1'b1);
    tick();
    chk("addr_cleared_p5", addr_m, 0);

    // Asynchronous reset around tap 40 abandons the pass.
    start_pass();
    n = 0;
    while (taps < 40 && n < 200) begin
      tick();
      n++;
    end
    chk("reached_tap40", taps >= 40, 1);
    @(negedge CLK);
    #3;
    RST = 1'b1;
    #1;
    outputs_zero("midpass_reset");
    sb.delete();
    flush_chk = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 100; i++) tick();
    chk("no_done_after_reset", dones, 0);
    chk("idle_after_midpass_reset", BUSY, 0);
    start_pass();
    wait_done(200, 1'b0);
    pass_checks(1'b1);
    tick();
    chk("addr_cleared_p6", addr_m, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

Interface
REQ-001 The module SHALL use parameters IFMAP_W default 5 (input feature-map width and height) and FILTER_W default 3 (filter width and height), with the stride fixed at 1.
REQ-002 The output size SHALL be OUT_W = IFMAP_W-FILTER_W+1, which is 3 at the default parameters.
REQ-003 The module SHALL have the following ports, listed as name, direction, width and meaning:
- CLK  in  1  single clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request one full convolution pass; sampled only in IDLE.
- READY  in  1  downstream MAC accepts a tap this cycle.
- ADDR_EN  out  1  drives EN of the image RAM address counter.
- IMAGE_idx_msel  out  3  step select for the address counter: 0 = +1, 1 = next filter row, 2 = next window in the same output row, 3 = first window of the next output row.
- ADDR_CLR  out  1  one-cycle registered pulse that returns the address counter to 0.
- TAP_VALID  out  1  the current counter address is a valid tap.
- TAP_FIRST  out  1  first tap of a window.
- TAP_LAST  out  1  last tap of a window.
- OFMAP_IDX  out  4  output pixel index, equal to orow*OUT_W+ocol.
- BUSY  out  1  high in RUN and FLUSH.
- DONE  out  1  one-cycle completion pulse.

Function
REQ-004 The FSM SHALL have the states IDLE, RUN, FLUSH and FIN, encoded in 2 bits.
REQ-005 IDLE SHALL go to RUN on the clock edge at which START=1; otherwise it SHALL stay in IDLE.
REQ-006 The block SHALL keep four counters, tcol, trow, ocol and orow, each ranging 0..FILTER_W-1 or 0..OUT_W-1, and SHALL zero all of them on entry to RUN.
REQ-007 In RUN with READY=1, TAP_VALID SHALL be 1, and the counters SHALL advance in this order at the clock edge: tcol, then trow, then ocol, then orow, each wrapping to 0.
REQ-008 In RUN with READY=0, TAP_VALID and ADDR_EN SHALL be 0 and all counters SHALL hold (stall).
REQ-009 IMAGE_idx_msel SHALL be decoded combinationally from the counters in this priority order:
- 0 when tcol<FILTER_W-1;
- else 1 when trow<FILTER_W-1;
- else 2 when ocol<OUT_W-1;
- else 3.
REQ-010 In any cycle where ADDR_EN=0, IMAGE_idx_msel SHALL be 0.
REQ-011 ADDR_EN SHALL equal TAP_VALID, except on the final tap (all four counters at their maximum), where ADDR_EN SHALL be 0 so that the counter is not stepped past the last address.
REQ-012 TAP_FIRST SHALL be TAP_VALID AND tcol=0 AND trow=0.
REQ-013 TAP_LAST SHALL be TAP_VALID AND tcol=FILTER_W-1 AND trow=FILTER_W-1.
REQ-014 OFMAP_IDX SHALL be valid whenever TAP_VALID=1.
REQ-015 After the final tap is accepted, the FSM SHALL go RUN->FLUSH for one cycle (RAM read latency), then FLUSH->FIN for one cycle, then FIN->IDLE.
REQ-016 In FIN, DONE and ADDR_CLR SHALL be 1; they SHALL be registered outputs and 0 in every other state.
REQ-017 With READY held at 1, a pass SHALL take OUT_W²·FILTER_W² tap cycles, which is 81 at the defaults.
REQ-018 At the defaults, DONE SHALL rise 83 cycles after the edge that samples START.
REQ-019 The block SHALL ignore START outside IDLE, and a START that is high in the FIN cycle SHALL NOT be queued.
REQ-020 The block SHALL tolerate READY toggling on any cycle, including on the final tap; the FSM SHALL leave RUN only when the final tap is accepted.
REQ-021 The per-window address deltas implied by the msel codes SHALL be +1, +(IFMAP_W-FILTER_W+1), -((FILTER_W-1)·IFMAP_W+FILTER_W-2) and -((FILTER_W-2)·IFMAP_W+IFMAP_W-1), which at the defaults are +1, +3, -11 and -9; the bench SHALL check these deltas using a counter model.

Reset
REQ-022 While RST=1, regardless of the clock, the block SHALL hold the state in IDLE, all counters at 0, ADDR_EN=0, IMAGE_idx_msel=0, ADDR_CLR=0, TAP_VALID/TAP_FIRST/TAP_LAST=0, OFMAP_IDX=0, BUSY=0 and DONE=0.
REQ-023 If RST is asserted mid-pass, the pass SHALL be abandoned and SHALL NOT produce a DONE pulse.
REQ-024 After RST deasserts, the block SHALL stay in IDLE until a new START.

Verification
REQ-025 Single pass, READY=1: pulse START; the address sequence SHALL be exactly 0,1,2,5,6,7,10,11,12,1,2,3,...,12,13,14,17,18,19,22,23,24; there SHALL be 81 taps; TAP_LAST SHALL occur 9 times; OFMAP_IDX SHALL run 0..8; DONE SHALL pulse at START+83.
REQ-026 msel at window boundaries: taps 8, 17 and 26 SHALL show msel 2, 2 and 3 with addresses 12->1, 13->2 and 14->5; the final tap SHALL show ADDR_EN=0 with the address held at 24.
REQ-027 Random READY stalls at about 50% duty: the tap/address sequence SHALL be identical to the READY=1 case; there SHALL be no ADDR_EN pulse while READY=0; DONE SHALL occur exactly once.
REQ-028 Back-to-back passes: after ADDR_CLR, the counter SHALL be 0; a START in the cycle after DONE SHALL repeat the identical 81-address sequence; START pulses in RUN SHALL have no effect.
REQ-029 Reset at tap 40: assert RST asynchronously between clock edges; all outputs SHALL be 0 immediately, there SHALL be no DONE, and a subsequent START SHALL begin from address 0 with OFMAP_IDX=0.
